// File: rtl/jt89_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt89_pkg : shared constants and types for the JT89 bus front end   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package jt89_pkg;

  localparam int LATCH_BIT     = 7;
  localparam int CHAN_MSB      = 6;
  localparam int CHAN_LSB      = 5;
  localparam int TYPE_BIT      = 4;

  localparam logic [3:0] VOL_OFF    = 4'hF;
  localparam logic [1:0] NOISE_CHAN = 2'd3;
  localparam logic [3:0] DIV_LAST   = 4'd15;

  localparam int READY_CNT_DEF = 32;

  typedef enum logic {
    REG_TONE = 1'b0,
    REG_VOL  = 1'b1
  } reg_type_e;

  typedef struct packed {
    logic [1:0] chan;
    reg_type_e  rtype;
  } latch_t;

endpackage
`default_nettype wire

// File: rtl/jt89_cendiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt89_cendiv : divides the chip-clock enable by 16 for tone/noise   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module jt89_cendiv
  import jt89_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cen,
  output logic clken16
);

  logic [3:0] r_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= 4'd0;
    end else if (cen) begin
      r_div <= r_div + 4'd1;
    end
  end

  assign clken16 = cen & (r_div == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/jt89_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt89_ctrl : SN76489-style write decoder, READY handshake, divider  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module jt89_ctrl
  import jt89_pkg::*;
#(
  parameter int READY_CNT = READY_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       ready,
  output logic       clken16,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise_ctl,
  output logic       noise_rst
);

  localparam int BW = $clog2(READY_CNT + 1);

  logic [BW-1:0] r_busy;
  logic          r_act_prev;
  latch_t        r_latch;
  logic [9:0]    r_tone [0:2];
  logic [3:0]    r_vol  [0:3];
  logic [2:0]    r_noise_ctl;
  logic          r_noise_rst;

  logic   w_act;
  logic   w_accept;
  logic   w_is_latch;
  latch_t w_sel;

  assign w_act      = ~cs_n & ~wr_n;
  assign ready      = (r_busy == '0);
  assign w_accept   = w_act & ~r_act_prev & ready;
  assign w_is_latch = din[LATCH_BIT];

  // A latch byte addresses itself; a data byte reuses the stored latch.
  always_comb begin
    w_sel = r_latch;
    if (w_is_latch) begin
      w_sel.chan  = din[CHAN_MSB:CHAN_LSB];
      w_sel.rtype = reg_type_e'(din[TYPE_BIT]);
    end
  end

  // Previous-act resets high so a strobe held through reset needs a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_prev <= 1'b1;
      r_busy     <= '0;
    end else begin
      r_act_prev <= w_act;
      if (w_accept) begin
        r_busy <= BW'(READY_CNT);
      end else if (cen && r_busy != '0) begin
        r_busy <= r_busy - BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch     <= '{chan: 2'd0, rtype: REG_TONE};
      r_noise_ctl <= 3'd0;
      r_noise_rst <= 1'b0;
      for (int i = 0; i < 3; i++) r_tone[i] <= 10'd0;
      for (int i = 0; i < 4; i++) r_vol[i]  <= VOL_OFF;
    end else begin
      r_noise_rst <= 1'b0;
      if (w_accept) begin
        r_latch <= w_sel;
        if (w_sel.rtype == REG_VOL) begin
          r_vol[w_sel.chan] <= din[3:0];
        end else if (w_sel.chan == NOISE_CHAN) begin
          r_noise_ctl <= din[2:0];
          r_noise_rst <= 1'b1;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (w_sel.chan == 2'(i)) begin
              if (w_is_latch) r_tone[i][3:0] <= din[3:0];
              else            r_tone[i][9:4] <= din[5:0];
            end
          end
        end
      end
    end
  end

  assign tone0     = r_tone[0];
  assign tone1     = r_tone[1];
  assign tone2     = r_tone[2];
  assign vol0      = r_vol[0];
  assign vol1      = r_vol[1];
  assign vol2      = r_vol[2];
  assign vol3      = r_vol[3];
  assign noise_ctl = r_noise_ctl;
  assign noise_rst = r_noise_rst;

  jt89_cendiv u_cendiv (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .clken16 (clken16)
  );

endmodule
`default_nettype wire

// File: tb/tb_jt89_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jt89_ctrl : self-checking bench for the JT89 bus front end      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_jt89_ctrl;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       cen  = 1'b1;
  logic [7:0] din  = 8'h00;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       ready, clken16, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise_ctl;

  int errors = 0;
  int checks = 0;
  bit cen_div3 = 1'b0;

  typedef struct {
    logic [7:0]  din;
    logic [9:0]  t0, t1, t2;
    logic [15:0] v;
    logic [2:0]  nc;
    logic        nr;
  } vec_t;

  vec_t vecs [12];
  vec_t sb [$];

  jt89_ctrl #(.READY_CNT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .din       (din),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .ready     (ready),
    .clken16   (clken16),
    .tone0     (tone0),
    .tone1     (tone1),
    .tone2     (tone2),
    .vol0      (vol0),
    .vol1      (vol1),
    .vol2      (vol2),
    .vol3      (vol3),
    .noise_ctl (noise_ctl),
    .noise_rst (noise_rst)
  );

  always #5 clk = ~clk;

  initial begin : cen_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cen_div3) begin
        ph  = (ph == 2) ? 0 : ph + 1;
        cen = (ph == 0);
      end else begin
        cen = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    if (!ready) chk("ready_timeout", {15'd0, ready}, 16'd1);
  endtask

  // Returns just after the edge that takes the write.
  task automatic write(input logic [7:0] d);
    wait_ready();
    din  = d;
    cs_n = 1'b0;
    wr_n = 1'b0;
    tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  task automatic check_sb;
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk("tone0", 16'(tone0), 16'(e.t0));
      chk("tone1", 16'(tone1), 16'(e.t1));
      chk("tone2", 16'(tone2), 16'(e.t2));
      chk("vols", {vol3, vol2, vol1, vol0}, e.v);
      chk("noise_ctl", 16'(noise_ctl), 16'(e.nc));
      chk("noise_rst", 16'(noise_rst), 16'(e.nr));
    end
  endtask

  initial begin : main
    int n, ncen, np, last;
    logic prev;

    vecs[0]  = '{8'h8E, 10'h00E, 10'h000, 10'h000, 16'hFFFF, 3'd0, 1'b0};
    vecs[1]  = '{8'h0F, 10'h0FE, 10'h000, 10'h000, 16'hFFFF, 3'd0, 1'b0};
    vecs[2]  = '{8'hB5, 10'h0FE, 10'h000, 10'h000, 16'hFF5F, 3'd0, 1'b0};
    vecs[3]  = '{8'h0A, 10'h0FE, 10'h000, 10'h000, 16'hFFAF, 3'd0, 1'b0};
    vecs[4]  = '{8'hE6, 10'h0FE, 10'h000, 10'h000, 16'hFFAF, 3'd6, 1'b1};
    vecs[5]  = '{8'h01, 10'h0FE, 10'h000, 10'h000, 16'hFFAF, 3'd1, 1'b1};
    vecs[6]  = '{8'hC3, 10'h0FE, 10'h000, 10'h003, 16'hFFAF, 3'd1, 1'b0};
    vecs[7]  = '{8'h3F, 10'h0FE, 10'h000, 10'h3F3, 16'hFFAF, 3'd1, 1'b0};
    vecs[8]  = '{8'hFA, 10'h0FE, 10'h000, 10'h3F3, 16'hAFAF, 3'd1, 1'b0};
    vecs[9]  = '{8'hA7, 10'h0FE, 10'h007, 10'h3F3, 16'hAFAF, 3'd1, 1'b0};
    vecs[10] = '{8'h25, 10'h0FE, 10'h257, 10'h3F3, 16'hAFAF, 3'd1, 1'b0};
    vecs[11] = '{8'h9C, 10'h0FE, 10'h257, 10'h3F3, 16'hAFAC, 3'd1, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tone0", 16'(tone0), 16'h0);
    chk("rst_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    chk("rst_noise_ctl", 16'(noise_ctl), 16'h0);
    chk("rst_noise_rst", 16'(noise_rst), 16'h0);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_clken16", 16'(clken16), 16'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      write(vecs[i].din);
      sb.push_back(vecs[i]);
      check_sb();
      if (i == 0) begin
        n = 0;
        while (!ready && n < 100) begin
          n++;
          tick();
        end
        chk("ready_low_cycles", 16'(n), 16'd32);
      end else begin
        tick();
        chk("noise_rst_off", 16'(noise_rst), 16'h0);
      end
    end

    // Edge while busy is dropped and not retaken when ready rises.
    write(8'h90);
    chk("busy_vol0_first", 16'(vol0), 16'h0);
    repeat (3) tick();
    din  = 8'h97;
    cs_n = 1'b0;
    wr_n = 1'b0;
    chk("busy_ready_low", 16'(ready), 16'h0);
    wait_ready();
    repeat (3) tick();
    chk("busy_dropped", 16'(vol0), 16'h0);
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
    write(8'h97);
    chk("busy_retry", 16'(vol0), 16'h7);

    // Strobe held through reset must deassert before it counts.
    wait_ready();
    rst  = 1'b1;
    din  = 8'h83;
    cs_n = 1'b0;
    wr_n = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("held_no_write", 16'(tone0), 16'h0);
    chk("held_ready", 16'(ready), 16'h1);
    cs_n = 1'b1;
    wr_n = 1'b1;
    tick();
    write(8'h83);
    chk("held_rewrite", 16'(tone0), 16'h003);

    // Reset while busy clears ready and the volume latch.
    write(8'hB5);
    chk("mid_vol1", 16'(vol1), 16'h5);
    chk("mid_busy", 16'(ready), 16'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 16'(ready), 16'h1);
    chk("mid_rst_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    rst = 1'b0;
    tick();
    write(8'h05);
    chk("mid_latch_lost_tone0", 16'(tone0), 16'h050);
    chk("mid_latch_lost_vol1", 16'(vol1), 16'hF);

    // Divider with cen every third clk.
    cen_div3 = 1'b1;
    rst = 1'b1;
    repeat (4) tick();
    rst  = 1'b0;
    ncen = 0;
    np   = 0;
    last = 0;
    prev = 1'b0;
    for (int c = 0; c < 210; c++) begin
      @(negedge clk);
      if (cen) ncen++;
      if (clken16) begin
        np++;
        chk("clken16_width", 16'(prev), 16'h0);
        if (np == 1) chk("clken16_first", 16'(ncen), 16'd16);
        else         chk("clken16_period", 16'(c - last), 16'd48);
        last = c;
      end
      prev = clken16;
    end
    chk("clken16_count", 16'(np), 16'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
